// File: rtl/btn_led_ctrl_pkg.sv
// Shared definitions for the front-panel button/LED controller: LED mode encoding
// and small helpers used by the controller and by any block that decodes mode.
package btn_led_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'd0;
    localparam mode_t MODE_ON   = 2'd1;
    localparam mode_t MODE_SLOW = 2'd2;
    localparam mode_t MODE_FAST = 2'd3;

    // Width of a counter that runs 0..term and never wraps beyond term.
    function automatic int cnt_width(input int term);
        return (term < 1) ? 1 : $clog2(term + 1);
    endfunction

    // OFF -> ON -> SLOW -> FAST -> OFF; the 2-bit add wraps FAST back to OFF.
    function automatic mode_t next_mode(input mode_t m);
        return m + mode_t'(1);
    endfunction

    function automatic logic led_drive(input mode_t m, input logic slow_phase,
                                       input logic fast_phase);
        case (m)
            MODE_OFF:  return 1'b0;
            MODE_ON:   return 1'b1;
            MODE_SLOW: return slow_phase;
            // NOTE: a default arm keeps every decode total, so nothing using it can infer a latch.
            default:   return fast_phase;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, tick-based debounce and a single-cycle
// pulse when the accepted level rises.
module btn_debounce
    import btn_led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_US = 10_000
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_every_us,
    output logic o_pressed
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_US - 1);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_US - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_pressed;
    logic [DB_W-1:0] r_cnt;
    logic            w_accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_accept = i_every_us && (r_cnt == DB_TERM) && (r_sync2 != r_stable);

    // Any return to the accepted level clears the count, so a bounce restarts the wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
        end else begin
            r_pressed <= w_accept && r_sync2;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (i_every_us) begin
                if (r_cnt == DB_TERM) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end
        end
    end

    assign o_pressed = r_pressed;

endmodule

// File: rtl/btn_led_ctrl.sv
// Front-panel controller: owns the 1 us / 1 ms tick chain, debounces CHANNELS buttons
// and steps each channel's LED mode on every accepted press.
module btn_led_ctrl
    import btn_led_ctrl_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int CLK_HZ        = 12_000_000,
    parameter int DEBOUNCE_US   = 10_000,
    parameter int MS_DIV        = 1000,
    parameter int BLINK_SLOW_MS = 500,
    parameter int BLINK_FAST_MS = 125
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        btn,
    output logic                       every_us,
    output logic [CHANNELS-1:0]        pressed,
    output logic [MODE_W*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]        led
);

    localparam int TICK_DIV = CLK_HZ / 1_000_000;
    localparam int US_W     = cnt_width(TICK_DIV - 1);
    localparam int MS_W     = cnt_width(MS_DIV - 1);
    localparam int SLOW_W   = cnt_width(BLINK_SLOW_MS - 1);
    localparam int FAST_W   = cnt_width(BLINK_FAST_MS - 1);

    localparam logic [US_W-1:0]   US_TERM   = US_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]   MS_TERM   = MS_W'(MS_DIV - 1);
    localparam logic [SLOW_W-1:0] SLOW_TERM = SLOW_W'(BLINK_SLOW_MS - 1);
    localparam logic [FAST_W-1:0] FAST_TERM = FAST_W'(BLINK_FAST_MS - 1);

    if (CLK_HZ % 1_000_000 != 0) begin : g_bad_clk
        $error("btn_led_ctrl: CLK_HZ must be an integer multiple of 1 MHz");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("btn_led_ctrl: CHANNELS must be in 1..16");
    end

    logic [US_W-1:0]   r_us_cnt;
    logic [MS_W-1:0]   r_ms_cnt;
    logic [SLOW_W-1:0] r_slow_cnt;
    logic [FAST_W-1:0] r_fast_cnt;
    logic              r_slow_phase;
    logic              r_fast_phase;
    logic              w_every_us;
    logic              w_ms_tick;
    logic [CHANNELS-1:0]              w_pressed;
    logic [CHANNELS-1:0][MODE_W-1:0]  r_mode;
    logic [CHANNELS-1:0]              r_led;

    assign w_every_us = (r_us_cnt == US_TERM);
    assign w_ms_tick  = w_every_us && (r_ms_cnt == MS_TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_us_cnt <= '0;
            r_ms_cnt <= '0;
        end else begin
            r_us_cnt <= w_every_us ? '0 : r_us_cnt + US_W'(1);
            if (w_every_us) begin
                r_ms_cnt <= (r_ms_cnt == MS_TERM) ? '0 : r_ms_cnt + MS_W'(1);
            end
        end
    end

    // Blink phases free-run from reset so every blinking channel shares one phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slow_cnt   <= '0;
            r_fast_cnt   <= '0;
            r_slow_phase <= 1'b0;
            r_fast_phase <= 1'b0;
        end else if (w_ms_tick) begin
            if (r_slow_cnt == SLOW_TERM) begin
                r_slow_cnt   <= '0;
                r_slow_phase <= ~r_slow_phase;
            end else begin
                r_slow_cnt <= r_slow_cnt + SLOW_W'(1);
            end
            if (r_fast_cnt == FAST_TERM) begin
                r_fast_cnt   <= '0;
                r_fast_phase <= ~r_fast_phase;
            end else begin
                r_fast_cnt <= r_fast_cnt + FAST_W'(1);
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_US (DEBOUNCE_US)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .i_btn      (btn[i]),
            .i_every_us (w_every_us),
            .o_pressed  (w_pressed[i])
        );
    end

    // NOTE: the mode array is control state, not storage, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= '0;
            r_led  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_pressed[i]) begin
                    r_mode[i] <= next_mode(r_mode[i]);
                end
                r_led[i] <= led_drive(r_mode[i], r_slow_phase, r_fast_phase);
            end
        end
    end

    assign every_us = w_every_us;
    assign pressed  = w_pressed;
    assign mode     = r_mode;
    assign led      = r_led;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Scoreboard bench for btn_led_ctrl: directed button stimulus, expected press/mode/LED
// results queued at stimulus time and checked by an independent monitor.
module tb_btn_led_ctrl;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] btn = '0;
    logic          every_us;
    logic [CH-1:0] pressed;
    logic [2*CH-1:0] mode;
    logic [CH-1:0] led;

    always #5 clk = ~clk;

    btn_led_ctrl #(
        .CHANNELS      (CH),
        .CLK_HZ        (4_000_000),
        .DEBOUNCE_US   (3),
        .MS_DIV        (4),
        .BLINK_SLOW_MS (2),
        .BLINK_FAST_MS (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .every_us (every_us),
        .pressed  (pressed),
        .mode     (mode),
        .led      (led)
    );

    typedef struct packed {
        logic [CH-1:0]   pressed;
        logic [2*CH-1:0] mode;
        logic [CH-1:0]   led_mask;
        logic [CH-1:0]   led_val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Ch2 mode-wrap sequence; ch0 and ch1 sit in ON throughout.
    logic [5:0] t4_mode [4] = '{6'b01_01_01, 6'b10_01_01, 6'b11_01_01, 6'b00_01_01};
    logic [2:0] t4_mask [4] = '{3'b111, 3'b011, 3'b011, 3'b111};
    logic [2:0] t4_val  [4] = '{3'b111, 3'b011, 3'b011, 3'b011};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_press(input logic [2:0] p, input logic [5:0] m,
                                input logic [2:0] mk, input logic [2:0] v);
        exp_t e;
        e.pressed  = p;
        e.mode     = m;
        e.led_mask = mk;
        e.led_val  = v;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic measure_toggle(input string name, input int ch, input int exp_period);
        logic prev;
        int   n;
        prev = led[ch];
        n = 0;
        while (led[ch] == prev && n < 100) begin
            @(negedge clk);
            n++;
        end
        prev = led[ch];
        n = 0;
        while (led[ch] == prev && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'(exp_period));
    endtask

    // Monitor: every press pulse is matched against the queue, then mode and LEDs follow.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pressed !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_press", 32'(pressed), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pressed", 32'(pressed), 32'(e.pressed));
                    @(negedge clk);
                    check("press_width", 32'(pressed), 32'd0);
                    check("mode", 32'(mode), 32'(e.mode));
                    @(negedge clk);
                    check("led", 32'(led & e.led_mask), 32'(e.led_val));
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with all buttons pressed.
        rst = 1'b0;
        btn = 3'b111;
        repeat (5) @(negedge clk);
        check("rst_led",      32'(led),      32'd0);
        check("rst_mode",     32'(mode),     32'd0);
        check("rst_pressed",  32'(pressed),  32'd0);
        check("rst_every_us", 32'(every_us), 32'd0);
        btn = 3'b000;
        repeat (3) @(negedge clk);

        // Release cycle is cycle 1 (count 0); every_us is high in cycles 4, 8, 12.
        rst = 1'b1;
        #1;
        check("every_us_c1", 32'(every_us), 32'd0);
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("every_us_c%0d", k), 32'(every_us), 32'(k % 4 == 0));
        end

        // Clean press on ch0.
        expect_press(3'b001, 6'b00_00_01, 3'b111, 3'b001);
        btn[0] = 1'b1;
        wait_drain("clean_ch0", 20);
        repeat (20) @(negedge clk);
        btn[0] = 1'b0;
        repeat (20) @(negedge clk);

        // Bounce on ch1: each level lasts 6 clocks, never long enough for 3 ticks.
        for (int s = 0; s < 10; s++) begin
            btn[1] = (s % 2 == 0);
            repeat (6) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("bounce_mode", 32'(mode), 32'(6'b00_00_01));
        expect_press(3'b010, 6'b00_01_01, 3'b111, 3'b011);
        btn[1] = 1'b1;
        wait_drain("held_ch1", 30);
        repeat (10) @(negedge clk);
        btn[1] = 1'b0;
        repeat (20) @(negedge clk);

        // Mode wrap on ch2 with blink period measurement.
        for (int p = 0; p < 4; p++) begin
            expect_press(3'b100, t4_mode[p], t4_mask[p], t4_val[p]);
            btn[2] = 1'b1;
            wait_drain($sformatf("wrap_ch2_p%0d", p), 30);
            repeat (5) @(negedge clk);
            btn[2] = 1'b0;
            repeat (20) @(negedge clk);
            if (p == 1) measure_toggle("slow_period", 2, 32);
            if (p == 2) measure_toggle("fast_period", 2, 16);
        end
        check("off_led2", 32'(led[2]), 32'd0);

        // Simultaneous presses on ch0 and ch2; ch1 must stay in ON.
        expect_press(3'b101, 6'b01_01_10, 3'b110, 3'b110);
        btn = 3'b101;
        wait_drain("simul", 30);
        repeat (5) @(negedge clk);
        btn = 3'b000;
        repeat (20) @(negedge clk);

        // Move ch0 to FAST, then reset while ch1 is mid-debounce.
        expect_press(3'b001, 6'b01_01_11, 3'b110, 3'b110);
        btn[0] = 1'b1;
        wait_drain("ch0_fast", 30);
        repeat (5) @(negedge clk);
        btn[0] = 1'b0;
        repeat (20) @(negedge clk);
        btn[1] = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_led",      32'(led),      32'd0);
        check("async_mode",     32'(mode),     32'd0);
        check("async_pressed",  32'(pressed),  32'd0);
        check("async_every_us", 32'(every_us), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        expect_press(3'b010, 6'b00_01_00, 3'b111, 3'b010);
        wait_drain("post_reset_ch1", 30);
        repeat (5) @(negedge clk);
        btn = 3'b000;
        repeat (20) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
